// File: rtl/result_readback_fifo.sv
// ============================================================================
// result_readback_fifo : result FIFO served to the host through a register slave
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module result_readback_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          op_clear,
  input  logic          push_valid,
  input  logic [DW-1:0] push_data,
  output logic          push_ready,
  input  logic          s_sel,
  input  logic          s_wr,
  input  logic [1:0]    s_addr,
  input  logic [DW-1:0] s_wdata,
  output logic [DW-1:0] s_rdata,
  output logic          s_rvalid,
  output logic          irq
);

  localparam logic [AW:0] c_DEPTH     = (AW+1)'(DEPTH);
  localparam logic [1:0]  c_A_DATA    = 2'd0;
  localparam logic [1:0]  c_A_STATUS  = 2'd1;
  localparam logic [1:0]  c_A_CTRL    = 2'd2;
  localparam logic [1:0]  c_A_THRESH  = 2'd3;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count, r_thresh;
  logic          r_ovf, r_udf;
  logic [DW-1:0] r_rdata;
  logic          r_rvalid, r_irq;

  logic          w_rd, w_wr, w_flush, w_clr_flags;
  logic          w_empty, w_full, w_pop_req, w_pop, w_push, w_ovf_evt, w_udf_evt;
  logic [AW:0]   w_count_next, w_thresh_next;
  logic          w_ovf_next, w_udf_next, w_irq_next;
  logic [DW-1:0] w_status, w_rdata_sel;

  assign w_rd        = s_sel & ~s_wr;
  assign w_wr        = s_sel & s_wr;
  assign w_flush     = op_clear | (w_wr && s_addr == c_A_CTRL && s_wdata[1]);
  assign w_clr_flags = w_wr && s_addr == c_A_CTRL && s_wdata[0];
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_DEPTH);
  assign w_pop_req   = w_rd && s_addr == c_A_DATA;
  assign w_pop       = w_pop_req & ~w_empty & ~w_flush;
  assign w_udf_evt   = w_pop_req & w_empty & ~w_flush;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push      = push_valid & (~w_full | w_pop) & ~w_flush;
  assign w_ovf_evt   = push_valid & w_full & ~w_pop & ~w_flush;
  assign push_ready  = ~w_full;

  always_comb begin
    w_count_next = r_count;
    if (w_flush)
      w_count_next = '0;
    else if (w_push && !w_pop)
      w_count_next = r_count + 1'b1;
    else if (w_pop && !w_push)
      w_count_next = r_count - 1'b1;
  end

  always_comb begin
    w_thresh_next = r_thresh;
    if (w_wr && s_addr == c_A_THRESH)
      w_thresh_next = s_wdata[AW:0];
  end

  // Same-cycle events beat the clear request, so a flag is never lost.
  assign w_ovf_next = w_flush ? 1'b0 : (w_ovf_evt ? 1'b1 : (w_clr_flags ? 1'b0 : r_ovf));
  assign w_udf_next = w_flush ? 1'b0 : (w_udf_evt ? 1'b1 : (w_clr_flags ? 1'b0 : r_udf));
  assign w_irq_next = (w_thresh_next != '0) && (w_count_next >= w_thresh_next);

  always_comb begin
    w_status       = '0;
    w_status[AW:0] = r_count;
    w_status[8]    = w_empty;
    w_status[9]    = w_full;
    w_status[10]   = r_ovf;
    w_status[11]   = r_udf;
  end

  always_comb begin
    w_rdata_sel = '0;
    case (s_addr)
      c_A_DATA:   w_rdata_sel = w_pop ? r_mem[r_rd_ptr] : '0;
      c_A_STATUS: w_rdata_sel = w_status;
      c_A_THRESH: w_rdata_sel = {{(DW-AW-1){1'b0}}, r_thresh};
      default:    w_rdata_sel = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_thresh <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count  <= w_count_next;
      r_thresh <= w_thresh_next;
      r_ovf    <= w_ovf_next;
      r_udf    <= w_udf_next;
      r_rvalid <= w_rd;
      if (w_rd)
        r_rdata <= w_rdata_sel;
      r_irq    <= w_irq_next;
    end
  end

  assign s_rdata  = r_rdata;
  assign s_rvalid = r_rvalid;
  assign irq      = r_irq;

endmodule

`default_nettype wire
